// File: rtl/ex_hazard_ctrl_if.sv
// Decode <-> EX hazard controller bundle: ID instruction fields and pc_select
// in, registered operand selects, stall/flush controls and perf counters out.
interface ex_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_src1_pc;
  logic                  id_src2_imm;
  logic                  pc_select;
  logic [SEL_W-1:0]      data1_sel_ALU;
  logic [SEL_W-1:0]      data2_sel_ALU;
  logic [SEL_W-1:0]      data1_sel_BJ;
  logic [SEL_W-1:0]      data2_sel_BJ;
  logic                  pc_write_en;
  logic                  if_id_write_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [31:0]           stall_count;
  logic [31:0]           flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_reg_write, id_mem_read, id_src1_pc, id_src2_imm, pc_select,
    input  data1_sel_ALU, data2_sel_ALU, data1_sel_BJ, data2_sel_BJ,
           pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_reg_write, id_mem_read, id_src1_pc, id_src2_imm, pc_select,
    output data1_sel_ALU, data2_sel_ALU, data1_sel_BJ, data2_sel_BJ,
           pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           stall_count, flush_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage forwarding / load-use / flush controller with a 3-entry dest scoreboard.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module ex_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  logic          clk,
  input  logic          rst,
  ex_hazard_ctrl_if.slave hz
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } sb_entry_t;

  localparam logic [SEL_W-1:0] SEL_REG = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ALT = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(3);

  // sb index 0 = EX, 1 = MEM, 2 = WB
  sb_entry_t [STAGES-1:0]  sb_q, sb_d;
  // sel index 0 = ALU1, 1 = ALU2, 2 = BJ1, 3 = BJ2
  logic [3:0][SEL_W-1:0]   sel_q, sel_d;

  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic load_use, stall, bubble;
  logic [SEL_W-1:0] f1, f2;

  function automatic logic match(sb_entry_t e, logic [REG_ADDR_W-1:0] src, logic uses);
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src) && uses;
  endfunction

  always_comb begin
    m1_ex    = match(sb_q[0], hz.id_rs1, hz.id_uses_rs1);
    m2_ex    = match(sb_q[0], hz.id_rs2, hz.id_uses_rs2);
    m1_mem   = match(sb_q[1], hz.id_rs1, hz.id_uses_rs1);
    m2_mem   = match(sb_q[1], hz.id_rs2, hz.id_uses_rs2);
    load_use = hz.id_valid && sb_q[0].mem_read && (m1_ex || m2_ex);
    stall    = load_use && !hz.pc_select;
    bubble   = hz.pc_select || stall;
    // Youngest producer wins: EX entry moves to MEM next cycle, MEM to WB.
    f1 = m1_ex ? SEL_MEM : (m1_mem ? SEL_WB : SEL_REG);
    f2 = m2_ex ? SEL_MEM : (m2_mem ? SEL_WB : SEL_REG);
  end

  always_comb begin
    sb_d[0].valid     = hz.id_valid && !bubble;
    sb_d[0].rd        = hz.id_rd;
    sb_d[0].reg_write = hz.id_reg_write;
    sb_d[0].mem_read  = hz.id_mem_read;
    sb_d[1]           = sb_q[0];
    sb_d[2]           = sb_q[1];
    sel_d             = '0;
    if (hz.id_valid && !bubble) begin
      sel_d[0] = hz.id_src1_pc  ? SEL_ALT : f1;
      sel_d[1] = hz.id_src2_imm ? SEL_ALT : f2;
      sel_d[2] = f1;
      sel_d[3] = f2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q  <= '0;
      sel_q <= '0;
    end else begin
      sb_q  <= sb_d;
      sel_q <= sel_d;
    end
  end

  // WB entry exists only for occupancy tracking; keep the shift honest.
  sb_shift_a: assert property (@(posedge clk) disable iff (rst) sb_q[2] == $past(sb_q[1]));

  assign hz.data1_sel_ALU  = sel_q[0];
  assign hz.data2_sel_ALU  = sel_q[1];
  assign hz.data1_sel_BJ   = sel_q[2];
  assign hz.data2_sel_BJ   = sel_q[3];
  // Scoreboard clears asynchronously, so stall is already low while rst is high.
  assign hz.pc_write_en    = !stall;
  assign hz.if_id_write_en = !stall;
  assign hz.if_id_flush    = hz.pc_select && !rst;
  assign hz.id_ex_bubble   = bubble && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall);
    flush_cnt_d = flush_cnt_q + 32'(hz.pc_select);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`else
  assign hz.stall_count = '0;
  assign hz.flush_count = '0;
`endif
endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard and forwarding controller for the EX stage. Sits between decode and the ID/EX register. It tracks destination-register state for the instructions in EX, MEM and WB, and computes the four EX-stage operand-select codes one cycle ahead, registering them so they arrive with the instruction. It also detects load-use hazards, which stall IF/ID and insert a bubble, and it flushes the front end when EX resolves a taken branch or jump.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- SEL_W, 2, operand-select code width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices
- id_rd  in  REG_ADDR_W  destination register index
- id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1 / rs2
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_src1_pc  in  1  ALU operand 1 is the PC
- id_src2_imm  in  1  ALU operand 2 is the immediate
- pc_select  in  1  EX branch/jump taken this cycle
- data1_sel_ALU, data2_sel_ALU  out  SEL_W  ALU operand selects, registered
- data1_sel_BJ, data2_sel_BJ  out  SEL_W  branch-compare and store-data selects, registered
- pc_write_en  out  1  PC may update
- if_id_write_en  out  1  IF/ID register may load
- if_id_flush  out  1  clear IF/ID to a bubble
- id_ex_bubble  out  1  load a bubble into ID/EX
- stall_count, flush_count  out  32  performance counters, only meaningful with the macro

## Operation
- Select encoding, shared by all four selects:
  - 0: register data
  - 1: PC or immediate; the BJ selects treat 1 as register data
  - 2: WB write-back data
  - 3: MEM ALU result
- Scoreboard: three entries (EX, MEM, WB), each {valid, rd, reg_write, mem_read}, shifted every cycle.
  - EX entry loads from the ID fields, or with valid=0 when a bubble is inserted.
- Match rule: a source operand matches an entry when all of the following hold:
  - entry valid=1 and reg_write=1
  - entry rd != 0
  - entry rd == the source index
  - the instruction uses that source
- Forwarding decision, made in ID for the next EX cycle:
  - Match against the current EX entry selects code 3, since that instruction will be in MEM.
  - Otherwise, a match against the current MEM entry selects code 2, since that instruction will be in WB.
  - Otherwise code 0.
  - The youngest producer wins.
- ALU selects: id_src1_pc forces data1_sel_ALU=1 and id_src2_imm forces data2_sel_ALU=1, regardless of any forwarding match.
- BJ selects always carry the pure forwarding result (0, 2 or 3).
- Load-use hazard: id_valid, the current EX entry has mem_read=1, and the EX entry matches rs1 or rs2. The response is:
  - pc_write_en=0 and if_id_write_en=0
  - id_ex_bubble=1, and the EX entry loads valid=0
  - all four registered selects load 0
- Flush (pc_select=1):
  - if_id_flush=1 and id_ex_bubble=1, and the EX entry loads valid=0
  - pc_write_en=1 and if_id_write_en=1
  - Flush has priority over a load-use stall in the same cycle; that stall is discarded.
- id_valid=0 is handled as a bubble: EX entry valid=0 and selects 0, with no stall.

## Timing
- Hazard detection and the pc_write_en, if_id_write_en, if_id_flush and id_ex_bubble outputs are combinational from the current inputs and scoreboard.
- Selects and scoreboard update on the rising edge. Latency is one cycle: the selects are valid during the instruction's EX cycle.
- A load-use stall lasts exactly one cycle. On the following cycle the load sits in MEM, forwarding uses code 2, and the stall releases.
- The register file writes before it reads, so a producer three instructions back needs no forwarding.
- Reset (asynchronous, active-high) drives:
  - all scoreboard valid bits to 0
  - all selects to 0
  - counters to 0
  - pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=0
- Reset asserted mid-stall drops the stall immediately. The first edge after release behaves as an empty pipeline.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments on every load-use stall cycle.
  - flush_count increments on every cycle with pc_select=1.
  - Both counters wrap at 2^32 and reset to 0.
- HAZARD_PERF_CNT_EN undefined: both counters are tied to 0 and no counter flops are generated.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: add x5 (EX), then add x6,x5,x5 in ID.
  - Required response: next cycle data1_sel_ALU=3 and data2_sel_ALU=3, with no stall.
- Dependency two instructions back:
  - Stimulus: add x5, then nop, then sub x7,x5,x1.
  - Required response: data1_sel_ALU=2 and data2_sel_ALU=0.
- Load-use:
  - Stimulus: lw x5 in EX, add x6,x5,x2 in ID.
  - Required response: pc_write_en=0 and id_ex_bubble=1 for one cycle; selects load 0 that cycle; the following cycle data1_sel_ALU=2. With the macro, stall_count=1.
- Register x0 and immediate override:
  - Stimulus: producer writes x0; consumer is addi x8,x0,4 with id_src2_imm=1.
  - Required response: data1_sel_ALU=0 and data2_sel_ALU=1.
- Flush beats stall:
  - Stimulus: pc_select=1 in the same cycle as a load-use match.
  - Required response: if_id_flush=1, id_ex_bubble=1, pc_write_en=1, and stall_count unchanged.
- Store-data forwarding and reset:
  - Stimulus: sw whose rs2 is produced by the instruction in MEM.
  - Required response: data2_sel_BJ=2.
  - Then assert rst mid-stream: all selects read 0 and the scoreboard is empty.
